dec_scan_seq: RTL and testbench
===============================

// Module: dec_scan_seq
// PURPOSE
//  Upstream sequencer for the 3-to-8 decoder stage (dec3to8_*). Generates the
//  {en, in[2:0]} select stream that scans decoder outputs 0..last_idx
//  cyclically. Each index is driven for DWELL cycles, followed by BLANK
//  cycles with en low (anti-ghosting gap). Used for LED/digit row scanning.
// PARAMETERS
//  DWELL  default 4  cycles en=1 per index; legal range 1..65535
//  BLANK  default 2  cycles en=0 between indices; 0 = no gap
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  synchronous, active-high reset
//  run         in   1  1 = scan; 0 = stop (abort) to IDLE
//  last_idx    in   3  highest index scanned; wrap back to 0 after it
//  in          out  3  decoder select (registered)
//  en          out  1  decoder enable (registered)
//  frame_done  out  1  one-cycle pulse when in wraps to 0
//  busy        out  1  1 while state != IDLE
// BEHAVIOUR
//  - Outputs are registered. Reset values: in=0, en=0, frame_done=0, busy=0,
//    state=IDLE, counter=0. rst has priority over everything, including run.
//  - Counter width is $clog2(max(DWELL,BLANK,2)). in increments mod 8 but
//    wraps at last_idx.
//  - FSM:
//    IDLE:   en=0, in=0. If run=1 at an edge -> ACTIVE, en=1, in=0, cnt=0
//            (en is high at the first edge that samples run=1).
//    ACTIVE: en=1, cnt counts up. When cnt==DWELL-1:
//            - BLANK>0: -> BLANK, en=0, cnt=0, in unchanged.
//            - BLANK==0: advance index (see below); stay in ACTIVE, en stays 1.
//    BLANK:  en=0, cnt counts up. When cnt==BLANK-1: advance index,
//            -> ACTIVE, en=1, cnt=0.
//  - Advance index: if in >= last_idx, set in=0 and frame_done=1 for exactly
//    the cycle in which the new index 0 is first presented. Otherwise
//    in=in+1. last_idx is sampled only at advance, so a mid-frame change
//    takes effect at the next advance. A lowered last_idx (in > last_idx)
//    wraps to 0 immediately.
//  - run=0 sampled in ACTIVE or BLANK: next edge -> IDLE, en=0, in=0, cnt=0,
//    frame_done=0. No partial-dwell completion.
//  - Re-asserting run always restarts at index 0 with a full DWELL.
//  - Period per index = DWELL+BLANK cycles. Frame = (last_idx+1)*(DWELL+BLANK).
//  - last_idx=0: index 0 is repeated; frame_done pulses on every advance.
//  - Simultaneous run=0 and advance: run=0 wins; no frame_done pulse.
//  - Under no condition does en=1 coincide with a changing in (glitch-free for
//    the decoder), except in BLANK==0 mode, where in steps while en stays 1.
// TESTING (DWELL=4, BLANK=2 unless stated)
//  1. rst=1 with run=1 for 3 cycles -> in=000, en=0, frame_done=0, busy=0 throughout.
//  2. run=1, last_idx=7 -> en 1,1,1,1,0,0 per index; in steps 0..7; frame_done pulses once
//     every 48 cycles, coincident with in=000 after 111.
//  3. last_idx=2 -> in sequence 0,1,2,0; frame_done period 18 cycles; never in>2.
//  4. run dropped at 2nd cycle of in=3 -> next edge en=0, in=0, busy=0; run re-raised -> in=0,
//     en=1 for full 4 cycles.
//  5. last_idx changed 7->1 while in=5 -> at next advance in=0 with frame_done=1, then 0,1,0.
//  6. BLANK=0, DWELL=1, last_idx=3 -> en constant 1, in=0,1,2,3,0 each cycle, frame_done every
//     4 cycles; rst mid-sequence -> all outputs 0 next edge.

Source files
------------

// File: rtl/dec_scan_seq_if.sv
// rtl/dec_scan_seq_if.sv - select-stream bundle between scan sequencer and decoder side
interface dec_scan_seq_if;
    logic       run;
    logic [2:0] last_idx;
    logic [2:0] in;
    logic       en;
    logic       frame_done;
    logic       busy;

    // master = sequencer producing the select stream
    modport master (
        input  run,
        input  last_idx,
        output in,
        output en,
        output frame_done,
        output busy
    );

    modport slave (
        output run,
        output last_idx,
        input  in,
        input  en,
        input  frame_done,
        input  busy
    );
endinterface

// File: rtl/dec_scan_seq.sv
// rtl/dec_scan_seq.sv - cyclic {en, in} scan sequencer for a 3-to-8 decoder
module dec_scan_seq #(
    parameter int DWELL = 4,
    parameter int BLANK = 2
) (
    input  logic          clk,
    input  logic          rst,
    dec_scan_seq_if.master bus
);
    localparam int MAXV = (DWELL > BLANK) ? ((DWELL > 2) ? DWELL : 2)
                                          : ((BLANK > 2) ? BLANK : 2);
    localparam int CW = $clog2(MAXV);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    in_q, in_d;
    logic          en_q, en_d;
    logic          fd_q, fd_d;

    logic          wrap;
    logic [2:0]    adv_in;

    // last_idx is only consulted here, so changes take effect at the next advance;
    // >= also catches a limit lowered below the current index
    assign wrap   = (in_q >= bus.last_idx);
    assign adv_in = wrap ? 3'd0 : in_q + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            in_q    <= 3'd0;
            en_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            en_q    <= en_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        en_d    = en_q;
        fd_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                in_d  = 3'd0;
                en_d  = 1'b0;
                if (bus.run) begin
                    state_d = S_ACTIVE;
                    en_d    = 1'b1;
                end
            end

            S_ACTIVE: begin
                if (!bus.run) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    in_d    = 3'd0;
                    en_d    = 1'b0;
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (BLANK > 0) begin
                        state_d = S_BLANK;
                        en_d    = 1'b0;
                    end else begin
                        // gapless mode: index steps while en stays high
                        in_d = adv_in;
                        fd_d = wrap;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_BLANK: begin
                if (!bus.run) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    in_d    = 3'd0;
                    en_d    = 1'b0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    in_d    = adv_in;
                    en_d    = 1'b1;
                    fd_d    = wrap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                in_d    = 3'd0;
                en_d    = 1'b0;
            end
        endcase
    end

    assign bus.in         = in_q;
    assign bus.en         = en_q;
    assign bus.frame_done = fd_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_dec_scan_seq.sv
// tb/tb_dec_scan_seq.sv - directed vector bench for dec_scan_seq
module tb_dec_scan_seq;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    dec_scan_seq_if bus_a ();
    dec_scan_seq_if bus_b ();

    dec_scan_seq #(.DWELL(4), .BLANK(2)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));
    dec_scan_seq #(.DWELL(1), .BLANK(0)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.master));

    typedef struct {
        logic       rst;
        logic       run;
        logic [2:0] last;
        logic [2:0] ein;
        logic       een;
        logic       efd;
        logic       ebusy;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(logic r, logic rn, logic [2:0] l,
                                logic [2:0] i, logic e, logic f, logic b);
        vec_t v;
        v.rst = r; v.run = rn; v.last = l;
        v.ein = i; v.een = e; v.efd = f; v.ebusy = b;
        vecs.push_back(v);
    endfunction

    // expected outputs of a DWELL=4/BLANK=2 scan k edges after start
    function automatic void add_scan(int k, logic [2:0] l, int frame_len);
        int idx;
        idx = (k / 6) % frame_len;
        add(1'b0, 1'b1, l, 3'(idx), (k % 6) < 4, (k > 0) && (k % 6 == 0) && (idx == 0), 1'b1);
    endfunction

    task automatic check(string name, int idx, logic [5:0] act, logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: {in,en,fd,busy} got %b want %b", name, idx, act, exp);
        end
    endtask

    initial begin
        bus_a.run = 1'b0; bus_a.last_idx = 3'd7;
        bus_b.run = 1'b0; bus_b.last_idx = 3'd3;

        // 1: reset dominates run
        for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0);
        // 2: full 8-index frame, wrap at edge 48
        for (int k = 0; k <= 54; k++) add_scan(k, 3'd7, 8);
        add(1'b1, 1'b0, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0);
        // 3: last_idx=2, frame of 18 cycles
        for (int k = 0; k <= 37; k++) add_scan(k, 3'd2, 3);
        add(1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        // run drop coinciding with the wrap advance: no frame_done
        for (int k = 0; k <= 17; k++) add_scan(k, 3'd2, 3);
        add(1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        // 4: drop run at second cycle of in=3, then restart with full dwell
        for (int k = 0; k <= 19; k++) add_scan(k, 3'd7, 8);
        add(1'b0, 1'b0, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= 6; k++) add_scan(k, 3'd7, 8);
        add(1'b1, 1'b0, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0);
        // 5: last_idx 7->1 while in=5; wraps at next advance, then 0,1,0
        for (int k = 0; k <= 50; k++) begin
            logic [2:0] l;
            l = (k < 31) ? 3'd7 : 3'd1;
            if (k < 36) add_scan(k, l, 8);
            else begin
                int j, idx;
                j = k - 36;
                idx = (j / 6) % 2;
                add(1'b0, 1'b1, l, 3'(idx), (j % 6) < 4, (j % 6 == 0) && (idx == 0), 1'b1);
            end
        end

        @(negedge clk);
        foreach (vecs[i]) begin
            rst_a = vecs[i].rst;
            bus_a.run = vecs[i].run;
            bus_a.last_idx = vecs[i].last;
            @(posedge clk);
            #1;
            check("scan_a", i, {bus_a.in, bus_a.en, bus_a.frame_done, bus_a.busy},
                  {vecs[i].ein, vecs[i].een, vecs[i].efd, vecs[i].ebusy});
        end

        // 6: gapless DWELL=1 mode, in steps every cycle with en held high
        rst_b = 1'b1;
        @(posedge clk); #1;
        check("b_reset", 0, {bus_b.in, bus_b.en, bus_b.frame_done, bus_b.busy}, 6'b000000);
        rst_b = 1'b0; bus_b.run = 1'b1; bus_b.last_idx = 3'd3;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("b_scan", k, {bus_b.in, bus_b.en, bus_b.frame_done, bus_b.busy},
                  {3'(k % 4), 1'b1, (k > 0) && (k % 4 == 0), 1'b1});
        end
        rst_b = 1'b1;
        @(posedge clk); #1;
        check("b_midrst", 0, {bus_b.in, bus_b.en, bus_b.frame_done, bus_b.busy}, 6'b000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
